// File: rtl/frog_grid.sv
// Frog position engine for the LED-matrix Frogger game: one position register,
// lives/score bookkeeping, a tick-timed death blink and a game-over state.
module frog_grid #(
    parameter int COLS        = 8,
    parameter int ROWS        = 8,
    parameter int START_X     = 3,
    parameter int START_Y     = 7,
    parameter int WRAP_X      = 0,
    parameter int LIVES       = 3,
    parameter int BLINK_TICKS = 4,
    localparam int XW         = $clog2(COLS),
    localparam int YW         = $clog2(ROWS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 L,
    input  logic                 R,
    input  logic                 U,
    input  logic                 D,
    input  logic                 crash,
    input  logic                 win,
    input  logic                 tick,
    output logic [ROWS*COLS-1:0] lightOn,
    output logic [XW-1:0]        frogX,
    output logic [YW-1:0]        frogY,
    output logic [2:0]           lives,
    output logic [3:0]           score,
    output logic                 gameOver
);

    localparam int N  = ROWS * COLS;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(BLINK_TICKS + 1);

    localparam logic [XW-1:0] X_START = XW'(START_X);
    localparam logic [YW-1:0] Y_START = YW'(START_Y);
    localparam logic [XW-1:0] X_MAX   = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_MAX   = YW'(ROWS - 1);
    localparam logic [2:0]    LV_INIT = 3'(LIVES);
    localparam logic [CW-1:0] CNT_END = CW'(BLINK_TICKS - 1);

    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        DYING = 2'd1,
        OVER  = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [XW-1:0] r_x, w_x_nxt;
    logic [YW-1:0] r_y, w_y_nxt;
    logic [2:0]    r_lives, w_lives_nxt;
    logic [3:0]    r_score, w_score_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_phase, w_phase_nxt;
    logic [IW-1:0] w_idx;
    logic          w_show;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ALIVE;
            r_x     <= X_START;
            r_y     <= Y_START;
            r_lives <= LV_INIT;
            r_score <= '0;
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_lives <= w_lives_nxt;
            r_score <= w_score_nxt;
            r_cnt   <= w_cnt_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_lives_nxt = r_lives;
        w_score_nxt = r_score;
        w_cnt_nxt   = r_cnt;
        w_phase_nxt = r_phase;
        case (r_state)
            ALIVE: begin
                if (crash) begin
                    w_lives_nxt = r_lives - 3'd1;
                    if (r_lives == 3'd1) begin
                        w_state_nxt = OVER;
                    end else begin
                        w_state_nxt = DYING;
                        w_cnt_nxt   = '0;
                        w_phase_nxt = 1'b0;
                    end
                end else if (win) begin
                    w_x_nxt     = X_START;
                    w_y_nxt     = Y_START;
                    w_score_nxt = sat_inc4(r_score);
                end else begin
                    // Only a single asserted direction is a legal move request.
                    case ({L, R, U, D})
                        4'b1000: begin
                            if (r_x != '0)       w_x_nxt = r_x - 1'b1;
                            else if (WRAP_X != 0) w_x_nxt = X_MAX;
                        end
                        4'b0100: begin
                            if (r_x != X_MAX)    w_x_nxt = r_x + 1'b1;
                            else if (WRAP_X != 0) w_x_nxt = '0;
                        end
                        4'b0010: if (r_y != '0)    w_y_nxt = r_y - 1'b1;
                        4'b0001: if (r_y != Y_MAX) w_y_nxt = r_y + 1'b1;
                        default: ;
                    endcase
                end
            end
            DYING: begin
                if (tick) begin
                    if (r_cnt == CNT_END) begin
                        w_state_nxt = ALIVE;
                        w_x_nxt     = X_START;
                        w_y_nxt     = Y_START;
                        w_cnt_nxt   = '0;
                        w_phase_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                        w_phase_nxt = ~r_phase;
                    end
                end
            end
            OVER: ;
            default: w_state_nxt = ALIVE;
        endcase
    end

    assign w_idx  = IW'(r_y) * IW'(COLS) + IW'(r_x);
    assign w_show = (r_state == ALIVE) || ((r_state == DYING) && r_phase);

    always_comb begin
        lightOn = '0;
        if (w_show) lightOn[w_idx] = 1'b1;
    end

    assign frogX    = r_x;
    assign frogY    = r_y;
    assign lives    = r_lives;
    assign score    = r_score;
    assign gameOver = (r_state == OVER);

endmodule

// File: tb/tb_frog_grid.sv
// Directed bench for frog_grid: a vector table for the main game flow plus
// hand-written sequences for wrap, score saturation and game over.
module tb_frog_grid;

    logic        clock = 1'b0;
    logic        reset, L, R, U, D, crash, win, tick;
    logic [63:0] lightOn, lightOn_w;
    logic [2:0]  frogX, frogY, lives, frogX_w, frogY_w, lives_w;
    logic [3:0]  score, score_w;
    logic        gameOver, gameOver_w;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    frog_grid dut (
        .clock(clock), .reset(reset), .L(L), .R(R), .U(U), .D(D),
        .crash(crash), .win(win), .tick(tick),
        .lightOn(lightOn), .frogX(frogX), .frogY(frogY),
        .lives(lives), .score(score), .gameOver(gameOver)
    );

    frog_grid #(.WRAP_X(1)) dut_w (
        .clock(clock), .reset(reset), .L(L), .R(R), .U(U), .D(D),
        .crash(crash), .win(win), .tick(tick),
        .lightOn(lightOn_w), .frogX(frogX_w), .frogY(frogY_w),
        .lives(lives_w), .score(score_w), .gameOver(gameOver_w)
    );

    localparam logic [7:0] I_0   = 8'h00;
    localparam logic [7:0] I_RST = 8'h80;
    localparam logic [7:0] I_L   = 8'h40;
    localparam logic [7:0] I_R   = 8'h20;
    localparam logic [7:0] I_U   = 8'h10;
    localparam logic [7:0] I_D   = 8'h08;
    localparam logic [7:0] I_C   = 8'h04;
    localparam logic [7:0] I_W   = 8'h02;
    localparam logic [7:0] I_T   = 8'h01;

    typedef struct {
        logic [7:0] in;
        int x, y, lv, sc, go, lit;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(input logic [7:0] in, input int x, input int y,
                                input int lv, input int sc, input int go, input int lit);
        vec_t v;
        v.in = in; v.x = x; v.y = y; v.lv = lv; v.sc = sc; v.go = go; v.lit = lit;
        return v;
    endfunction

    function automatic logic [63:0] bit_at(input int x, input int y);
        return 64'd1 << (y * 8 + x);
    endfunction

    task automatic step(input logic [7:0] v);
        @(negedge clock);
        {reset, L, R, U, D, crash, win, tick} = v;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        {reset, L, R, U, D, crash, win, tick} = I_RST;

        tbl[0]  = mk(I_RST,         3, 7, 3, 0, 0, 1);
        tbl[1]  = mk(I_U,           3, 6, 3, 0, 0, 1);
        tbl[2]  = mk(I_U,           3, 5, 3, 0, 0, 1);
        tbl[3]  = mk(I_U,           3, 4, 3, 0, 0, 1);
        tbl[4]  = mk(I_U | I_L,     3, 4, 3, 0, 0, 1);
        tbl[5]  = mk(I_D | I_R,     3, 4, 3, 0, 0, 1);
        tbl[6]  = mk(I_D,           3, 5, 3, 0, 0, 1);
        tbl[7]  = mk(I_C,           3, 5, 2, 0, 0, 0);
        tbl[8]  = mk(I_0,           3, 5, 2, 0, 0, 0);
        tbl[9]  = mk(I_T,           3, 5, 2, 0, 0, 1);
        tbl[10] = mk(I_U,           3, 5, 2, 0, 0, 1);
        tbl[11] = mk(I_0,           3, 5, 2, 0, 0, 1);
        tbl[12] = mk(I_T,           3, 5, 2, 0, 0, 0);
        tbl[13] = mk(I_L | I_C,     3, 5, 2, 0, 0, 0);
        tbl[14] = mk(I_T,           3, 5, 2, 0, 0, 1);
        tbl[15] = mk(I_W,           3, 5, 2, 0, 0, 1);
        tbl[16] = mk(I_T,           3, 7, 2, 0, 0, 1);
        tbl[17] = mk(I_C | I_T,     3, 7, 1, 0, 0, 0);
        tbl[18] = mk(I_T,           3, 7, 1, 0, 0, 1);
        tbl[19] = mk(I_T,           3, 7, 1, 0, 0, 0);
        tbl[20] = mk(I_RST,         3, 7, 3, 0, 0, 1);
        tbl[21] = mk(I_T,           3, 7, 3, 0, 0, 1);
        tbl[22] = mk(I_W,           3, 7, 3, 1, 0, 1);
        tbl[23] = mk(I_D,           3, 7, 3, 1, 0, 1);
        tbl[24] = mk(I_C | I_W,     3, 7, 2, 1, 0, 0);

        for (int i = 0; i < 25; i++) begin
            logic [63:0] exp_light;
            step(tbl[i].in);
            exp_light = (tbl[i].lit != 0) ? bit_at(tbl[i].x, tbl[i].y) : 64'd0;
            chk($sformatf("vec%0d_state", i),
                {50'd0, frogX, frogY, lives, score, gameOver},
                {50'd0, 3'(tbl[i].x), 3'(tbl[i].y), 3'(tbl[i].lv), 4'(tbl[i].sc), 1'(tbl[i].go)});
            chk($sformatf("vec%0d_light", i), lightOn, exp_light);
            if (i == 3) chk("bit35_after_3U", lightOn, 64'h0000_0008_0000_0000);
        end

        // Horizontal edge: blocked on the default build, wraps on the WRAP_X build
        step(I_RST);
        chk("reset_light_bit59", lightOn, 64'h0800_0000_0000_0000);
        repeat (3) step(I_L);
        chk("left3_x", {61'd0, frogX}, 64'd0);
        step(I_L);
        chk("left_edge_block_x", {61'd0, frogX}, 64'd0);
        chk("left_edge_wrap_x", {61'd0, frogX_w}, 64'd7);
        chk("left_edge_wrap_light", lightOn_w, 64'h8000_0000_0000_0000);
        step(I_R);
        chk("right_edge_wrap_x", {61'd0, frogX_w}, 64'd0);
        chk("right_nowrap_x", {61'd0, frogX}, 64'd1);
        repeat (6) step(I_R);
        step(I_R);
        chk("right_edge_block_x", {61'd0, frogX}, 64'd7);

        // Reach the goal row, win, then saturate the score
        step(I_RST);
        repeat (7) step(I_U);
        chk("top_row_y", {61'd0, frogY}, 64'd0);
        step(I_U);
        chk("top_edge_block_y", {61'd0, frogY}, 64'd0);
        step(I_W);
        chk("win_pos", {58'd0, frogX, frogY}, {58'd0, 3'd3, 3'd7});
        chk("win_score1", {60'd0, score}, 64'd1);
        chk("win_light", lightOn, 64'h0800_0000_0000_0000);
        repeat (20) step(I_W);
        chk("score_saturate", {60'd0, score}, 64'd15);

        // Three crashes with full blinks lead to game over
        step(I_RST);
        for (int k = 0; k < 2; k++) begin
            step(I_C);
            repeat (4) begin
                step(I_T);
                step(I_0);
            end
        end
        chk("two_deaths_lives", {61'd0, lives}, 64'd1);
        chk("two_deaths_alive_light", lightOn, 64'h0800_0000_0000_0000);
        step(I_C);
        chk("over_flag", {63'd0, gameOver}, 64'd1);
        chk("over_lives", {61'd0, lives}, 64'd0);
        chk("over_light", lightOn, 64'd0);
        step(I_U | I_C | I_W | I_T);
        step(I_L);
        step(I_W);
        chk("over_hold", {50'd0, frogX, frogY, lives, score, gameOver},
            {50'd0, 3'd3, 3'd7, 3'd0, 4'd0, 1'b1});
        chk("over_hold_light", lightOn, 64'd0);
        step(I_RST);
        chk("over_reset_lives", {61'd0, lives}, 64'd3);
        chk("over_reset_flag", {63'd0, gameOver}, 64'd0);
        chk("over_reset_light", lightOn, 64'h0800_0000_0000_0000);

        step(I_0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
